hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 6-stage RV32I core (IF ID EX MEM WB_ WB); it pairs with the EX-stage forwarding unit.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard sequencer: register/word aliases,
// sequencer and MDU-handshake state encodings, and the RAW-match helper.
package hazard_ctrl_pkg;

  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;

  typedef enum logic {RUN, DISCARD}  hzd_state_t;
  typedef enum logic {M_IDLE, M_WAIT} mdu_state_t;

  localparam rv32i_reg REG_X0 = 5'd0;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic raw_hazard(rv32i_reg rd, rv32i_reg rs, logic use_rs);
    return use_rs && (rd == rs) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: hazard sources in, per-register load/flush
// enables, redirect/MDU handshake and perf counters out.
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32) ();

  rv32i_reg   rs1_ID, rs2_ID, rd_EX;
  logic       use_rs1_ID, use_rs2_ID, memread_EX;
  logic       imem_read, imem_resp, dmem_req, dmem_resp;
  logic       br_taken_EX, mdu_op_EX, mdu_done;
  rv32i_word  br_target_EX;

  logic       ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic       pc_pend_sel, mdu_start;
  rv32i_word  pend_tgt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, use_rs1_ID, use_rs2_ID, memread_EX,
           imem_read, imem_resp, dmem_req, dmem_resp, br_taken_EX, br_target_EX,
           mdu_op_EX, mdu_done,
    input  ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_pend_sel, pend_tgt,
           mdu_start, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, use_rs1_ID, use_rs2_ID, memread_EX,
           imem_read, imem_resp, dmem_req, dmem_resp, br_taken_EX, br_target_EX,
           mdu_op_EX, mdu_done,
    output ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_pend_sel, pend_tgt,
           mdu_start, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: count advances on the edge after inc, sticks at all-ones.
// No backpressure; inc is sampled every cycle.
module hazard_ctrl_sat_counter #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + CNT_W'(1);
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// 6-stage RV32I hazard sequencer: same-cycle load/flush enables from hazard inputs,
// pending-redirect capture across I-fetch misses, MDU launch handshake, perf counters.
module hazard_ctrl import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  hzd_state_t r_state, w_state_nxt;
  mdu_state_t r_mdu_st, w_mdu_nxt;
  rv32i_word  r_pend_tgt;

  logic w_dstall, w_mstall, w_imiss, w_loaduse, w_redirect, w_capture;
  logic w_ld_pc, w_ld_if_id, w_ld_id_ex, w_ld_ex_mem, w_ld_mem_wb;
  logic w_fl_if_id, w_fl_id_ex, w_fl_ex_mem, w_pc_pend_sel, w_mdu_start;
  logic w_stall_inc;
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  assign w_dstall   = bus.dmem_req & ~bus.dmem_resp;
  assign w_mstall   = bus.mdu_op_EX & ~bus.mdu_done;
  assign w_imiss    = bus.imem_read & ~bus.imem_resp;
  assign w_loaduse  = bus.memread_EX &
                      (raw_hazard(bus.rd_EX, bus.rs1_ID, bus.use_rs1_ID) |
                       raw_hazard(bus.rd_EX, bus.rs2_ID, bus.use_rs2_ID));
  assign w_redirect = bus.br_taken_EX & ~w_dstall & ~w_mstall;

  always_comb begin
    w_ld_pc = 1'b1; w_ld_if_id = 1'b1; w_ld_id_ex = 1'b1; w_ld_ex_mem = 1'b1; w_ld_mem_wb = 1'b1;
    w_fl_if_id = 1'b0; w_fl_id_ex = 1'b0; w_fl_ex_mem = 1'b0;
    w_pc_pend_sel = 1'b0;
    w_capture     = 1'b0;
    w_state_nxt   = r_state;
    if (!rst_n || w_dstall) begin
      w_ld_pc = 1'b0; w_ld_if_id = 1'b0; w_ld_id_ex = 1'b0; w_ld_ex_mem = 1'b0; w_ld_mem_wb = 1'b0;
    end else begin
      if (w_mstall) begin
        w_ld_pc = 1'b0; w_ld_if_id = 1'b0; w_ld_id_ex = 1'b0; w_ld_ex_mem = 1'b0;
        w_fl_ex_mem = 1'b1;
      end else if (w_redirect) begin
        w_fl_if_id = 1'b1;
        w_fl_id_ex = 1'b1;
      end else if (w_loaduse) begin
        w_ld_pc = 1'b0; w_ld_if_id = 1'b0;
        w_fl_id_ex = 1'b1;
      end
      // Fetch side: in DISCARD the PC only moves once the wrong-path fetch returns.
      if (r_state == DISCARD) begin
        w_fl_if_id = 1'b1;
        if (bus.imem_resp) begin
          w_ld_pc       = 1'b1;
          w_pc_pend_sel = ~w_redirect;
          w_state_nxt   = RUN;
        end else begin
          w_ld_pc   = 1'b0;
          w_capture = w_redirect;
        end
      end else if (w_redirect) begin
        if (w_imiss) begin
          w_ld_pc     = 1'b0;
          w_capture   = 1'b1;
          w_state_nxt = DISCARD;
        end
      end else if (!w_mstall && !w_loaduse && w_imiss) begin
        w_ld_pc    = 1'b0;
        w_fl_if_id = 1'b1;
      end
    end
  end

  always_comb begin
    w_mdu_nxt   = r_mdu_st;
    w_mdu_start = 1'b0;
    case (r_mdu_st)
      M_IDLE: if (rst_n && bus.mdu_op_EX && !w_dstall) begin
        w_mdu_start = 1'b1;
        w_mdu_nxt   = M_WAIT;
      end
      M_WAIT: if (bus.mdu_done) w_mdu_nxt = M_IDLE;
      default: w_mdu_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_mdu_st   <= M_IDLE;
      r_pend_tgt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mdu_st <= w_mdu_nxt;
      if (w_capture) r_pend_tgt <= bus.br_target_EX;
    end
  end

  assign w_stall_inc = ~(w_ld_pc & w_ld_if_id & w_ld_id_ex & w_ld_ex_mem);

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_stall_inc), .count(w_stall_cnt)
  );

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_redirect), .count(w_flush_cnt)
  );

  assign bus.ld_pc        = w_ld_pc;
  assign bus.ld_if_id     = w_ld_if_id;
  assign bus.ld_id_ex     = w_ld_id_ex;
  assign bus.ld_ex_mem    = w_ld_ex_mem;
  assign bus.ld_mem_wb    = w_ld_mem_wb;
  assign bus.flush_if_id  = w_fl_if_id;
  assign bus.flush_id_ex  = w_fl_id_ex;
  assign bus.flush_ex_mem = w_fl_ex_mem;
  assign bus.pc_pend_sel  = w_pc_pend_sel;
  assign bus.pend_tgt     = r_pend_tgt;
  assign bus.mdu_start    = w_mdu_start;
  assign bus.stall_cnt    = w_stall_cnt;
  assign bus.flush_cnt    = w_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each cycle's expected enables are queued
// as stimulus is applied and checked at the following falling edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] FRZ = 5'b00000;
  localparam logic [4:0] MST = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       tag;
    logic [4:0]  ld;
    logic [2:0]  fl;
    logic        ps;
    logic        ms;
    logic        fc;
    logic        ck_tgt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Pops one expectation per cycle; counters are checked against a saturating tally
  // of the stall/redirect cycles the bench itself expected on earlier cycles.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stall = '0;
      m_flush = '0;
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("%s.ld", e.tag),
          32'({bus.ld_pc, bus.ld_if_id, bus.ld_id_ex, bus.ld_ex_mem, bus.ld_mem_wb}), 32'(e.ld));
      chk($sformatf("%s.flush", e.tag),
          32'({bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}), 32'(e.fl));
      chk($sformatf("%s.pc_pend_sel", e.tag), 32'(bus.pc_pend_sel), 32'(e.ps));
      chk($sformatf("%s.mdu_start", e.tag), 32'(bus.mdu_start), 32'(e.ms));
      chk($sformatf("%s.stall_cnt", e.tag), 32'(bus.stall_cnt), 32'(m_stall));
      chk($sformatf("%s.flush_cnt", e.tag), 32'(bus.flush_cnt), 32'(m_flush));
      if (e.ck_tgt) chk($sformatf("%s.pend_tgt", e.tag), bus.pend_tgt, e.tgt);
      if ((e.ld[4:1] != 4'hF) && (m_stall != CMAX)) m_stall = m_stall + 1'b1;
      if (e.fc && (m_flush != CMAX)) m_flush = m_flush + 1'b1;
    end
  end

  task automatic idle();
    bus.rs1_ID = '0; bus.rs2_ID = '0; bus.rd_EX = '0;
    bus.use_rs1_ID = 1'b0; bus.use_rs2_ID = 1'b0; bus.memread_EX = 1'b0;
    bus.imem_read = 1'b0; bus.imem_resp = 1'b0; bus.dmem_req = 1'b0; bus.dmem_resp = 1'b0;
    bus.br_taken_EX = 1'b0; bus.br_target_EX = '0; bus.mdu_op_EX = 1'b0; bus.mdu_done = 1'b0;
  endtask

  // Queue this cycle's expectation, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [4:0] ld, input logic [2:0] fl,
                      input logic ps, input logic ms, input logic fc,
                      input logic ck_tgt, input logic [31:0] tgt);
    exp_t e;
    e.tag = tag; e.ld = ld; e.fl = fl; e.ps = ps; e.ms = ms; e.fc = fc;
    e.ck_tgt = ck_tgt; e.tgt = tgt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ld"}, 32'({bus.ld_pc, bus.ld_if_id, bus.ld_id_ex, bus.ld_ex_mem, bus.ld_mem_wb}), 32'd0);
    chk({tag, ".flush"}, 32'({bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}), 32'd0);
    chk({tag, ".ps_ms"}, 32'({bus.pc_pend_sel, bus.mdu_start}), 32'd0);
    chk({tag, ".pend_tgt"}, bus.pend_tgt, 32'd0);
    chk({tag, ".cnts"}, 32'({bus.stall_cnt, bus.flush_cnt}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    step("idle", ALL, 3'b000, 0, 0, 0, 1, 32'h0);

    // Load-use on rs1 / rs2, then the cases that must not interlock.
    bus.memread_EX = 1; bus.rd_EX = 5'd5; bus.rs1_ID = 5'd5; bus.use_rs1_ID = 1;
    bus.rs2_ID = 5'd1; bus.use_rs2_ID = 1;
    step("lu_rs1", 5'b00111, 3'b010, 0, 0, 0, 0, 0);
    idle();
    step("lu_bubble", ALL, 3'b000, 0, 0, 0, 0, 0);
    bus.memread_EX = 1; bus.rd_EX = 5'd7; bus.rs2_ID = 5'd7; bus.use_rs2_ID = 1;
    step("lu_rs2", 5'b00111, 3'b010, 0, 0, 0, 0, 0);
    idle(); bus.memread_EX = 1; bus.rd_EX = 5'd0; bus.rs1_ID = 5'd0; bus.use_rs1_ID = 1;
    step("lu_x0", ALL, 3'b000, 0, 0, 0, 0, 0);
    idle(); bus.memread_EX = 1; bus.rd_EX = 5'd5; bus.rs1_ID = 5'd5; bus.use_rs1_ID = 0;
    step("lu_nouse", ALL, 3'b000, 0, 0, 0, 0, 0);
    idle(); bus.memread_EX = 0; bus.rd_EX = 5'd5; bus.rs1_ID = 5'd5; bus.use_rs1_ID = 1;
    step("lu_noload", ALL, 3'b000, 0, 0, 0, 0, 0);

    // D-miss: three frozen cycles, released in the response cycle.
    idle(); bus.dmem_req = 1;
    for (int i = 0; i < 3; i++) step("dstall", FRZ, 3'b000, 0, 0, 0, 0, 0);
    bus.dmem_resp = 1;
    step("dresp", ALL, 3'b000, 0, 0, 0, 0, 0);

    // D-miss with a mul in EX: launch deferred to the response cycle.
    idle(); bus.dmem_req = 1; bus.mdu_op_EX = 1;
    for (int i = 0; i < 3; i++) step("dstall_mdu", FRZ, 3'b000, 0, 0, 0, 0, 0);
    bus.dmem_resp = 1;
    step("mdu_launch_late", MST, 3'b001, 0, 1, 0, 0, 0);
    bus.dmem_req = 0; bus.dmem_resp = 0;
    for (int i = 0; i < 2; i++) step("mdu_wait", MST, 3'b001, 0, 0, 0, 0, 0);
    bus.mdu_done = 1;
    step("mdu_done", ALL, 3'b000, 0, 0, 0, 0, 0);

    // Divide: 7 stalled cycles, done in the 8th, then a back-to-back mul relaunches.
    idle(); bus.mdu_op_EX = 1;
    step("div_start", MST, 3'b001, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("div_wait", MST, 3'b001, 0, 0, 0, 0, 0);
    bus.mdu_done = 1;
    step("div_done", ALL, 3'b000, 0, 0, 0, 0, 0);
    bus.mdu_done = 0;
    step("mul_start", MST, 3'b001, 0, 1, 0, 0, 0);
    bus.mdu_done = 1;
    step("mul_done", ALL, 3'b000, 0, 0, 0, 0, 0);

    // I-miss alone, and load-use outranking it.
    idle(); bus.imem_read = 1;
    step("istall", 5'b01111, 3'b100, 0, 0, 0, 0, 0);
    bus.memread_EX = 1; bus.rd_EX = 5'd9; bus.rs1_ID = 5'd9; bus.use_rs1_ID = 1;
    step("lu_over_istall", 5'b00111, 3'b010, 0, 0, 0, 0, 0);

    // Redirect with no fetch outstanding.
    idle(); bus.br_taken_EX = 1; bus.br_target_EX = 32'h40;
    step("br_plain", ALL, 3'b110, 0, 0, 1, 0, 0);
    idle();
    step("br_plain_after", ALL, 3'b000, 0, 0, 0, 1, 32'h0);

    // Redirect during I-miss: capture, discard, resume from pend_tgt.
    bus.imem_read = 1; bus.br_taken_EX = 1; bus.br_target_EX = 32'h60;
    step("br_miss", 5'b01111, 3'b110, 0, 0, 1, 0, 0);
    bus.br_taken_EX = 0; bus.br_target_EX = 32'h0;
    step("discard1", 5'b01111, 3'b100, 0, 0, 0, 1, 32'h60);
    bus.memread_EX = 1; bus.rd_EX = 5'd3; bus.rs2_ID = 5'd3; bus.use_rs2_ID = 1;
    step("discard_lu", 5'b00111, 3'b110, 0, 0, 0, 1, 32'h60);
    idle(); bus.imem_read = 1; bus.imem_resp = 1;
    step("discard_resp", ALL, 3'b100, 1, 0, 0, 1, 32'h60);
    idle();
    step("after_discard", ALL, 3'b000, 0, 0, 0, 0, 0);

    // Second redirect overwrites pend_tgt; a D-miss freezes DISCARD even on imem_resp.
    bus.imem_read = 1; bus.br_taken_EX = 1; bus.br_target_EX = 32'h80;
    step("br_miss2", 5'b01111, 3'b110, 0, 0, 1, 0, 0);
    bus.br_target_EX = 32'h90;
    step("br_overwrite", 5'b01111, 3'b110, 0, 0, 1, 1, 32'h80);
    idle(); bus.imem_read = 1; bus.imem_resp = 1; bus.dmem_req = 1;
    step("discard_dfrz", FRZ, 3'b000, 0, 0, 0, 1, 32'h90);
    bus.dmem_req = 0;
    step("discard_resp2", ALL, 3'b100, 1, 0, 0, 1, 32'h90);
    idle();
    step("run_again", ALL, 3'b000, 0, 0, 0, 0, 0);

    // Reset while in DISCARD and M_WAIT.
    bus.imem_read = 1; bus.br_taken_EX = 1; bus.br_target_EX = 32'h44;
    step("br_miss3", 5'b01111, 3'b110, 0, 0, 1, 0, 0);
    bus.br_taken_EX = 0; bus.mdu_op_EX = 1;
    step("discard_mdu", MST, 3'b101, 0, 1, 0, 1, 32'h44);
    step("discard_mwait", MST, 3'b101, 0, 0, 0, 1, 32'h44);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    rst_n = 1'b1;
    bus.imem_resp = 1;
    step("post_rst_run", MST, 3'b001, 0, 1, 0, 1, 32'h0);
    idle(); bus.mdu_op_EX = 1; bus.mdu_done = 1;
    step("post_rst_done", ALL, 3'b000, 0, 0, 0, 0, 0);

    // Stall counter saturation.
    idle(); bus.imem_read = 1;
    for (int i = 0; i < 70; i++) step("sat", 5'b01111, 3'b100, 0, 0, 0, 0, 0);
    chk("stall_sat", 32'(bus.stall_cnt), 32'(CMAX));
    idle();
    step("sat_hold", ALL, 3'b000, 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
